ami_r: RTL and testbench

//  AXI4 master read interface (AMI read): the initiator-side counterpart of the AXI slave read port.

---
 rtl/ami_r.sv | 199 +++++++++++++++++++
 tb/tb_ami_r.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ami_r.sv
// AXI4 master read engine: splits one user read command into INCR bursts
// (bounded by MAX_BL and 4KB pages), keeps up to MST_OD bursts in flight,
// and streams the returned R beats to user logic with protocol checking.
module ami_r #(
    parameter int unsigned AXI_DW = 128,
    parameter int unsigned AXI_AW = 40,
    parameter int unsigned AXI_IW = 8,
    parameter int unsigned AXI_LW = 8,
    parameter int unsigned MST_OD = 4,
    parameter int unsigned MAX_BL = 16,
    parameter int unsigned CMD_LW = 16,
    parameter int unsigned MST_ID = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AXI_AW-1:0] cmd_addr,
    input  logic [CMD_LW-1:0] cmd_beats,
    output logic              busy,
    output logic              err_proto,
    output logic [AXI_IW-1:0] ARID,
    output logic [AXI_AW-1:0] ARADDR,
    output logic [AXI_LW-1:0] ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [AXI_IW-1:0] RID,
    input  logic [AXI_DW-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [AXI_DW-1:0] usr_rdata,
    output logic              usr_rvalid,
    input  logic              usr_rready,
    output logic              usr_rlast,
    output logic              usr_rerr
);

    localparam int unsigned BYTES = AXI_DW / 8;
    localparam int unsigned BSH   = $clog2(BYTES);
    localparam int unsigned OW    = $clog2(MST_OD + 1);
    localparam int unsigned PW    = (MST_OD > 1) ? $clog2(MST_OD) : 1;
    localparam int unsigned BLW   = $clog2(MAX_BL + 1);

    localparam logic [OW-1:0]     OdFull   = OW'(MST_OD);
    localparam logic [AXI_IW-1:0] IdExp    = AXI_IW'(MST_ID);
    localparam logic [PW-1:0]     PtrLast  = PW'(MST_OD - 1);
    localparam logic [AXI_AW-1:0] AddrMask = ~(AXI_AW'(BYTES - 1));

    typedef enum logic [1:0] {StIdle, StAddr, StWait} state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [AXI_AW-1:0] r_addr;
    logic [CMD_LW-1:0] r_rem;
    logic              r_arvalid;
    logic [OW-1:0]     r_out;
    logic [OW-1:0]     w_out_nxt;
    logic [BLW-1:0]    r_fifo [MST_OD];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [BLW-1:0]    r_cnt;
    logic              r_err;

    logic [12:0]       w_page;
    logic [31:0]       w_bl;
    logic              w_accept;
    logic              w_ar_hs;
    logic              w_ar_last;
    logic              w_has_out;
    logic              w_rhs;
    logic              w_acc;
    logic              w_stray;
    logic [BLW-1:0]    w_head;
    logic              w_exp_last;
    logic              w_pop;
    logic              w_beat_bad;
    logic              w_unused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PtrLast) ? '0 : p + PW'(1);
    endfunction

    assign w_accept   = cmd_valid & (r_state == StIdle);
    assign w_ar_hs    = r_arvalid & ARREADY;
    assign w_ar_last  = (32'(r_rem) == w_bl);
    assign w_has_out  = (r_out != '0);
    assign w_rhs      = RVALID & RREADY;
    assign w_acc      = w_rhs & w_has_out;
    assign w_stray    = w_rhs & ~w_has_out;
    assign w_head     = r_fifo[r_rptr];
    assign w_exp_last = (r_cnt == w_head - BLW'(1));
    assign w_pop      = w_acc & w_exp_last;
    // The beat counter decides where a burst ends; RLAST is only cross-checked.
    assign w_beat_bad = (RLAST != w_exp_last) | (RID != IdExp);
    assign w_unused   = RRESP[0];

    assign cmd_ready  = (r_state == StIdle);
    assign busy       = (r_state != StIdle);
    assign err_proto  = r_err;
    assign ARID       = IdExp;
    assign ARADDR     = r_addr;
    assign ARLEN      = r_arvalid ? AXI_LW'(w_bl - 32'd1) : '0;
    assign ARSIZE     = 3'(BSH);
    assign ARBURST    = 2'b01;
    assign ARVALID    = r_arvalid;
    // With nothing outstanding, R beats are drained unconditionally and dropped.
    assign RREADY     = w_has_out ? usr_rready : 1'b1;
    assign usr_rdata  = RDATA;
    assign usr_rvalid = RVALID & w_has_out;
    assign usr_rerr   = usr_rvalid & RRESP[1];
    assign usr_rlast  = usr_rvalid & w_exp_last & (r_state == StWait) & (r_out == OW'(1));

    // Burst length: limited by remaining beats, MAX_BL and distance to the 4KB page end.
    always_comb begin
        w_page = 13'h1000 - {1'b0, r_addr[11:0]};
        w_bl   = 32'(r_rem);
        if (w_bl > MAX_BL) w_bl = MAX_BL;
        if (w_bl > 32'(w_page >> BSH)) w_bl = 32'(w_page >> BSH);
    end

    // Outstanding-burst count: push and pop in the same cycle cancel.
    always_comb begin
        w_out_nxt = r_out;
        if (w_ar_hs && !w_pop) begin
            w_out_nxt = r_out + OW'(1);
        end else if (!w_ar_hs && w_pop) begin
            w_out_nxt = r_out - OW'(1);
        end
    end

    // Next-state logic for the command FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (cmd_valid && cmd_beats != '0) w_state_nxt = StAddr;
            StAddr:  if (w_ar_hs && w_ar_last) w_state_nxt = StWait;
            StWait:  if (w_out_nxt == '0) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    // Address/remaining tracking, AR valid generation, R beat accounting, sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_rem     <= '0;
            r_arvalid <= 1'b0;
            r_out     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            if (w_accept) begin
                r_addr    <= cmd_addr & AddrMask;
                r_rem     <= cmd_beats;
                r_arvalid <= (cmd_beats != '0);
            end else if (r_state == StAddr) begin
                if (w_ar_hs) begin
                    // Drop valid for one cycle so the next length is computed from updated state.
                    r_addr    <= r_addr + (AXI_AW'(w_bl) << BSH);
                    r_rem     <= r_rem - CMD_LW'(w_bl);
                    r_arvalid <= 1'b0;
                end else if (!r_arvalid && r_out < OdFull) begin
                    r_arvalid <= 1'b1;
                end
            end
            if (w_ar_hs) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)   r_rptr <= ptr_inc(r_rptr);
            if (w_acc)   r_cnt  <= w_exp_last ? '0 : r_cnt + BLW'(1);
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_stray || (w_acc && w_beat_bad)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Length FIFO: one entry per issued burst, consumed as bursts complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MST_OD; i++) r_fifo[i] <= '0;
        end else if (w_ar_hs) begin
            r_fifo[r_wptr] <= BLW'(w_bl);
        end
    end

endmodule

// File: tb/tb_ami_r.sv
// Directed bench for ami_r: a small AXI read slave model answers bursts with
// address-patterned data; user-side beats are checked against hand-computed values.
module tb_ami_r;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [39:0]  cmd_addr;
    logic [15:0]  cmd_beats;
    logic         busy;
    logic         err_proto;
    logic [7:0]   ARID;
    logic [39:0]  ARADDR;
    logic [7:0]   ARLEN;
    logic [2:0]   ARSIZE;
    logic [1:0]   ARBURST;
    logic         ARVALID;
    logic         ARREADY;
    logic [7:0]   RID;
    logic [127:0] RDATA;
    logic [1:0]   RRESP;
    logic         RLAST;
    logic         RVALID;
    logic         RREADY;
    logic [127:0] usr_rdata;
    logic         usr_rvalid;
    logic         usr_rready;
    logic         usr_rlast;
    logic         usr_rerr;

    always #5 clk = ~clk;

    ami_r dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_beats(cmd_beats), .busy(busy), .err_proto(err_proto),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid), .usr_rready(usr_rready),
        .usr_rlast(usr_rlast), .usr_rerr(usr_rerr)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [39:0] rq_addr [$];
    int          rq_len [$];
    logic [39:0] ar_addr_log [$];
    int          ar_len_log [$];
    int          ar_cyc [$];
    int          pop_cyc [$];
    int          r_beat = 0;
    int          gbeat = 0;
    int          usr_cnt = 0;
    int          total = 0;
    logic [39:0] exp_base = '0;
    int          r_hold_until = 0;
    bit          ar_stall_en = 1'b0;
    bit          rr_toggle = 1'b0;
    bit          stray_en = 1'b0;
    int          rerr_at = -1;
    int          early_last_at = -1;
    int          ar_wait = 0;
    bit          ar_prev_stall = 1'b0;
    logic [39:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;
    int          t_start;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive slave/user inputs at negedge, observe handshakes, advance past posedge.
    task automatic step();
        int off;
        int blen;
        @(negedge clk);
        ARREADY = !(ar_stall_en && ARVALID && ar_wait < 5);
        if (stray_en) begin
            RVALID = 1'b1; RLAST = 1'b1; RRESP = 2'b00; RID = 8'd0; RDATA = '0;
        end else if (cyc >= r_hold_until && rq_addr.size() != 0) begin
            RVALID = 1'b1;
            RID    = 8'd0;
            RDATA  = 128'(rq_addr[0] + 40'(r_beat * 16));
            RLAST  = (r_beat == rq_len[0]) ^ (gbeat == early_last_at);
            RRESP  = (gbeat == rerr_at) ? 2'b10 : 2'b00;
        end else begin
            RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        end
        usr_rready = rr_toggle ? (cyc % 2 == 0) : 1'b1;
        #1;
        if (ar_prev_stall) begin
            check_eq("ar_hold_valid", 64'(ARVALID), 64'd1);
            check_eq("ar_hold_addr", 64'(ARADDR), 64'(prev_addr));
            check_eq("ar_hold_len", 64'(ARLEN), 64'(prev_len));
        end
        ar_prev_stall = ARVALID && !ARREADY;
        prev_addr = ARADDR;
        prev_len  = ARLEN;
        if (ARVALID && ARREADY) begin
            off  = int'(ARADDR[11:0]);
            blen = int'(ARLEN) + 1;
            check_eq("ar_no_4k_cross", 64'((off + blen * 16) <= 4096), 64'd1);
            check_eq("ar_fixed", 64'({ARID, ARSIZE, ARBURST}), 64'({8'd0, 3'd4, 2'b01}));
            ar_addr_log.push_back(ARADDR);
            ar_len_log.push_back(int'(ARLEN));
            ar_cyc.push_back(cyc);
            rq_addr.push_back(ARADDR);
            rq_len.push_back(int'(ARLEN));
            ar_wait = 0;
        end else if (ARVALID) begin
            ar_wait++;
        end
        if (stray_en) begin
            check_eq("stray_rready", 64'(RREADY), 64'd1);
            check_eq("stray_usr_rvalid", 64'(usr_rvalid), 64'd0);
        end else if (RVALID) begin
            check_eq("rready_follows_user", 64'(RREADY), 64'(usr_rready));
            check_eq("usr_rvalid", 64'(usr_rvalid), 64'd1);
        end
        if (usr_rvalid && usr_rready) begin
            check_eq("usr_data", 64'(usr_rdata[39:0]), 64'(exp_base + 40'(usr_cnt * 16)));
            check_eq("usr_rlast", 64'(usr_rlast), 64'(usr_cnt == total - 1));
            check_eq("usr_rerr", 64'(usr_rerr), 64'(usr_cnt == rerr_at));
            usr_cnt++;
        end
        if (RVALID && RREADY && !stray_en) begin
            if (r_beat == rq_len[0]) begin
                void'(rq_addr.pop_front());
                void'(rq_len.pop_front());
                pop_cyc.push_back(cyc);
                r_beat = 0;
            end else begin
                r_beat++;
            end
            gbeat++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_logs();
        ar_addr_log.delete(); ar_len_log.delete(); ar_cyc.delete(); pop_cyc.delete();
        usr_cnt = 0; gbeat = 0; r_beat = 0;
    endtask

    task automatic run_cmd(input logic [39:0] addr, input int beats, input int budget);
        bit done;
        clear_logs();
        exp_base  = addr & ~40'hF;
        total     = beats;
        cmd_addr  = addr;
        cmd_beats = 16'(beats);
        cmd_valid = 1'b1;
        check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
        check_eq("first_arvalid", 64'(ARVALID), 64'(beats != 0));
        check_eq("busy_after_accept", 64'(busy), 64'(beats != 0));
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = !busy && usr_cnt == total && rq_addr.size() == 0;
        end
        check_eq("cmd_done_in_budget", 64'(done), 64'd1);
        check_eq("usr_beat_count", 64'(usr_cnt), 64'(total));
    endtask

    task automatic check_ar(input string tag, input int idx, input logic [39:0] a, input int l);
        check_eq({tag, "_addr"}, 64'(ar_addr_log[idx]), 64'(a));
        check_eq({tag, "_len"}, 64'(ar_len_log[idx]), 64'(l));
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
        ARREADY = 1'b1; RVALID = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0;
        usr_rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_arvalid", 64'(ARVALID), 64'd0);
        check_eq("rst_araddr", 64'(ARADDR), 64'd0);
        check_eq("rst_arlen", 64'(ARLEN), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_err", 64'(err_proto), 64'd0);
        check_eq("rst_fixed", 64'({ARID, ARSIZE, ARBURST}), 64'({8'd0, 3'd4, 2'b01}));
        check_eq("rst_rready", 64'(RREADY), 64'd1);
        rst_n = 1'b1;
        step();

        // Three bursts, last one short.
        run_cmd(40'h0, 40, 200);
        check_eq("t1_ar_count", 64'(ar_addr_log.size()), 64'd3);
        check_ar("t1_ar0", 0, 40'h000, 15);
        check_ar("t1_ar1", 1, 40'h100, 15);
        check_ar("t1_ar2", 2, 40'h200, 7);
        check_eq("t1_err", 64'(err_proto), 64'd0);

        // 4KB page split; low address bits ignored.
        run_cmd(40'hFC7, 8, 100);
        check_eq("t2_ar_count", 64'(ar_addr_log.size()), 64'd2);
        check_ar("t2_ar0", 0, 40'hFC0, 3);
        check_ar("t2_ar1", 1, 40'h1000, 3);

        // Outstanding limit with R held off.
        t_start = cyc;
        r_hold_until = cyc + 30;
        run_cmd(40'h10000, 128, 600);
        r_hold_until = 0;
        check_eq("t3_ar_count", 64'(ar_addr_log.size()), 64'd8);
        check_eq("t3_four_early", 64'(ar_cyc.size() > 3 && ar_cyc[3] < t_start + 30), 64'd1);
        check_eq("t3_fifth_after_pop",
                 64'(ar_cyc.size() > 4 && pop_cyc.size() > 0 && ar_cyc[4] > pop_cyc[0]), 64'd1);

        // ARREADY stalls and user back-pressure.
        ar_stall_en = 1'b1;
        rr_toggle   = 1'b1;
        run_cmd(40'h2000, 20, 300);
        ar_stall_en = 1'b0;
        rr_toggle   = 1'b0;
        check_eq("t4_ar_count", 64'(ar_addr_log.size()), 64'd2);
        check_ar("t4_ar0", 0, 40'h2000, 15);
        check_ar("t4_ar1", 1, 40'h2100, 3);

        // Error response on beat 3, early RLAST on beat 10.
        rerr_at = 2;
        early_last_at = 9;
        run_cmd(40'h3000, 16, 100);
        rerr_at = -1;
        early_last_at = -1;
        check_eq("t5_err_set", 64'(err_proto), 64'd1);
        repeat (3) step();
        check_eq("t5_err_sticky", 64'(err_proto), 64'd1);
        run_cmd(40'h4000, 0, 5);
        check_eq("t5_err_cleared", 64'(err_proto), 64'd0);
        check_eq("zero_cmd_no_ar", 64'(ar_addr_log.size()), 64'd0);

        // Reset in the middle of address issue with two bursts outstanding.
        clear_logs();
        r_hold_until = cyc + 1000;
        cmd_addr = 40'h0; cmd_beats = 16'd64; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int c = 0; c < 20 && ar_addr_log.size() < 2; c++) step();
        check_eq("t6_two_ar", 64'(ar_addr_log.size()), 64'd2);
        check_eq("t6_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_arvalid", 64'(ARVALID), 64'd0);
        check_eq("t6_busy", 64'(busy), 64'd0);
        check_eq("t6_cmd_ready", 64'(cmd_ready), 64'd1);
        step();
        check_eq("t6_arvalid_next", 64'(ARVALID), 64'd0);
        check_eq("t6_rready_no_out", 64'(RREADY), 64'd1);
        rst_n = 1'b1;
        rq_addr.delete(); rq_len.delete(); r_beat = 0;
        r_hold_until = 0;
        ar_prev_stall = 1'b0;
        stray_en = 1'b1;
        step();
        stray_en = 1'b0;
        check_eq("t6_stray_err", 64'(err_proto), 64'd1);
        run_cmd(40'h5000, 4, 50);
        check_eq("t6_recover_err", 64'(err_proto), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
